// File: rtl/grid_cursor_picker.sv
// grid_cursor_picker
//   Moves a cursor over a ROWS x COLS tile grid. Held direction keys
//   auto-repeat. A select key picks two tiles, and the pair is handed to the
//   match-check logic over a valid/ready handshake.
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   up/down/left/right    debounced direction levels
//   sel                   select level; only its rising edge acts
//   cancel                drops a held first pick (level)
//   cur_bus / cur_idx     cursor position, one-hot (bit=row*COLS+col) and binary
//   pick_bus              one-hot first pick, zero when nothing is held
//   pair_valid/a/b        picked pair towards the match logic
//   pair_ready            consumer accepts the pair
module grid_cursor_picker #(
    parameter int ROWS          = 6,
    parameter int COLS          = 6,
    parameter int WRAP          = 1,
    parameter int START_IDX     = 0,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4,
    localparam int N  = ROWS * COLS,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up,
    input  logic          down,
    input  logic          left,
    input  logic          right,
    input  logic          sel,
    input  logic          cancel,
    output logic [N-1:0]  cur_bus,
    output logic [IW-1:0] cur_idx,
    output logic [N-1:0]  pick_bus,
    output logic          pair_valid,
    output logic [IW-1:0] pair_a,
    output logic [IW-1:0] pair_b,
    input  logic          pair_ready
);

    localparam int RW   = $clog2(ROWS);
    localparam int CLW  = $clog2(COLS);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW   = $clog2(RMAX + 1);

    localparam logic [RW-1:0]  START_ROW = RW'(START_IDX / COLS);
    localparam logic [CLW-1:0] START_COL = CLW'(START_IDX % COLS);
    localparam logic [RW-1:0]  LAST_ROW  = RW'(ROWS - 1);
    localparam logic [CLW-1:0] LAST_COL  = CLW'(COLS - 1);

    typedef enum logic [1:0] {IDLE, ONE, PAIR} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CLW-1:0]  col_q, col_d;
    logic [3:0]      dir_q, dir_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sel_q, sel_d;
    logic [N-1:0]    cur_bus_q, cur_bus_d;
    logic [IW-1:0]   cur_idx_q, cur_idx_d;
    logic [N-1:0]    pick_bus_q, pick_bus_d;
    logic            pair_valid_q, pair_valid_d;
    logic [IW-1:0]   pair_a_q, pair_a_d;
    logic [IW-1:0]   pair_b_q, pair_b_d;

    logic step;
    logic sel_rise;

    // Move decision and row/column update. Row and column are kept apart so
    // the binary index is a constant multiply-add, never a divide.
    always_comb begin
        dir_d = {up, down, left, right};
        step  = 1'b0;
        cnt_d = cnt_q;
        if (dir_d == 4'b0000) begin
            cnt_d = '0;
        end else if (dir_d != dir_q) begin
            step  = 1'b1;
            cnt_d = CW'(REPEAT_DELAY);
        end else if (cnt_q <= CW'(1)) begin
            step  = 1'b1;
            cnt_d = CW'(REPEAT_PERIOD);
        end else begin
            cnt_d = cnt_q - CW'(1);
        end

        row_d = row_q;
        col_d = col_q;
        if (step) begin
            if (up && !down)
                row_d = (row_q == '0) ? ((WRAP != 0) ? LAST_ROW : row_q) : row_q - RW'(1);
            else if (down && !up)
                row_d = (row_q == LAST_ROW) ? ((WRAP != 0) ? '0 : row_q) : row_q + RW'(1);
            if (left && !right)
                col_d = (col_q == '0) ? ((WRAP != 0) ? LAST_COL : col_q) : col_q - CLW'(1);
            else if (right && !left)
                col_d = (col_q == LAST_COL) ? ((WRAP != 0) ? '0 : col_q) : col_q + CLW'(1);
        end

        cur_idx_d = IW'(int'(row_d) * COLS + int'(col_d));
        cur_bus_d = N'(1) << cur_idx_d;
    end

    // Pick FSM. It samples the registered (pre-move) cursor, so a move and a
    // select in the same cycle pick the tile the user was looking at.
    always_comb begin
        sel_d        = sel;
        sel_rise     = sel & ~sel_q;
        state_d      = state_q;
        pick_bus_d   = pick_bus_q;
        pair_valid_d = pair_valid_q;
        pair_a_d     = pair_a_q;
        pair_b_d     = pair_b_q;
        case (state_q)
            IDLE: begin
                if (sel_rise) begin
                    pair_a_d   = cur_idx_q;
                    pick_bus_d = cur_bus_q;
                    state_d    = ONE;
                end
            end
            ONE: begin
                if (cancel) begin
                    pick_bus_d = '0;
                    state_d    = IDLE;
                end else if (sel_rise) begin
                    if (cur_idx_q == pair_a_q) begin
                        pick_bus_d = '0;
                        state_d    = IDLE;
                    end else begin
                        pair_b_d     = cur_idx_q;
                        pair_valid_d = 1'b1;
                        state_d      = PAIR;
                    end
                end
            end
            PAIR: begin
                if (pair_ready) begin
                    pair_valid_d = 1'b0;
                    pick_bus_d   = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            row_q        <= START_ROW;
            col_q        <= START_COL;
            dir_q        <= '0;
            cnt_q        <= '0;
            sel_q        <= 1'b0;
            cur_idx_q    <= IW'(START_IDX);
            cur_bus_q    <= N'(1) << START_IDX;
            pick_bus_q   <= '0;
            pair_valid_q <= 1'b0;
            pair_a_q     <= '0;
            pair_b_q     <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            dir_q        <= dir_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            cur_idx_q    <= cur_idx_d;
            cur_bus_q    <= cur_bus_d;
            pick_bus_q   <= pick_bus_d;
            pair_valid_q <= pair_valid_d;
            pair_a_q     <= pair_a_d;
            pair_b_q     <= pair_b_d;
        end
    end

    assign cur_bus    = cur_bus_q;
    assign cur_idx    = cur_idx_q;
    assign pick_bus   = pick_bus_q;
    assign pair_valid = pair_valid_q;
    assign pair_a     = pair_a_q;
    assign pair_b     = pair_b_q;

endmodule
